// File: rtl/operand_capture.sv
// Debounced button-triggered operand capture with valid/ready release.
// Optional capture counter output enabled by defining CAPTURE_COUNT_EN.
module operand_capture #(
   parameter int WIDTH           = 16,
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic [WIDTH-1:0]   SW_SYNC,
   input  logic               BTN_SYNC,
   input  logic               READY,
   output logic [WIDTH/2-1:0] OP_A,
   output logic [WIDTH/2-1:0] OP_B,
   output logic               VALID,
`ifdef CAPTURE_COUNT_EN
   output logic [7:0]         CAPT_CNT,
`endif
   output logic               BUSY
);

   localparam int HW = WIDTH / 2;
   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE,
      DB_PRESS,
      CAPT_VALID,
      WAIT_REL
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [HW-1:0]   op_a_q, op_a_d;
   logic [HW-1:0]   op_b_q, op_b_d;
   logic            valid_q, valid_d;
   logic            busy_q, busy_d;
   logic            xfer;

   assign xfer  = valid_q && READY;
   assign OP_A  = op_a_q;
   assign OP_B  = op_b_q;
   assign VALID = valid_q;
   assign BUSY  = busy_q;

   // Next-state logic: debounce press, hold operands, debounce release
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_a_d  = op_a_q;
      op_b_d  = op_b_q;
      unique case (state_q)
         IDLE: begin
            if (BTN_SYNC) begin
               state_d = DB_PRESS;
               cnt_d   = '0;
            end
         end
         DB_PRESS: begin
            if (!BTN_SYNC) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == CNT_MAX) begin
               state_d = CAPT_VALID;
               cnt_d   = '0;
               op_a_d  = SW_SYNC[WIDTH-1:HW];
               op_b_d  = SW_SYNC[HW-1:0];
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         CAPT_VALID: begin
            if (xfer) begin
               state_d = WAIT_REL;
               cnt_d   = '0;
            end
         end
         WAIT_REL: begin
            if (BTN_SYNC) begin
               cnt_d = '0;
            end else if (cnt_q == CNT_MAX) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
      valid_d = (state_d == CAPT_VALID);
      busy_d  = (state_d != IDLE);
   end

   // State, counter and registered outputs
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         op_a_q  <= '0;
         op_b_q  <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_a_q  <= op_a_d;
         op_b_q  <= op_b_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
      end
   end

`ifdef CAPTURE_COUNT_EN
   logic [7:0] capt_cnt_q, capt_cnt_d;

   assign CAPT_CNT = capt_cnt_q;

   // Count completed transfers, wrapping at 8 bits
   always_comb begin
      capt_cnt_d = capt_cnt_q;
      if (xfer) capt_cnt_d = capt_cnt_q + 8'd1;
   end

   // Transfer counter register
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) capt_cnt_q <= '0;
      else      capt_cnt_q <= capt_cnt_d;
   end
`endif

endmodule

// File: tb/tb_operand_capture.sv
// Directed self-checking bench for operand_capture (DEBOUNCE_CYCLES=4).
// Covers reset, capture, bounce, handshake, release and optional counter.
module tb_operand_capture;

   logic        CLK = 1'b0;
   logic        RST;
   logic [15:0] SW_SYNC;
   logic        BTN_SYNC;
   logic        READY;
   logic [7:0]  OP_A;
   logic [7:0]  OP_B;
   logic        VALID;
   logic        BUSY;
`ifdef CAPTURE_COUNT_EN
   logic [7:0]  CAPT_CNT;
`endif

   int total = 0;
   int bad   = 0;
   int vcnt;

   operand_capture #(
      .WIDTH(16),
      .DEBOUNCE_CYCLES(4)
   ) dut (
      .CLK(CLK),
      .RST(RST),
      .SW_SYNC(SW_SYNC),
      .BTN_SYNC(BTN_SYNC),
      .READY(READY),
      .OP_A(OP_A),
      .OP_B(OP_B),
      .VALID(VALID),
`ifdef CAPTURE_COUNT_EN
      .CAPT_CNT(CAPT_CNT),
`endif
      .BUSY(BUSY)
   );

   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      RST = 1'b0;
      SW_SYNC = 16'h0000;
      BTN_SYNC = 1'b0;
      READY = 1'b0;
      tick();
      tick();
      RST = 1'b1;
      tick();
      chk("rst_valid", {31'd0, VALID}, 32'd0);
      chk("rst_busy", {31'd0, BUSY}, 32'd0);
      chk("rst_op", {16'd0, OP_A, OP_B}, 32'h0);

      // clean press, READY low
      SW_SYNC = 16'h0C07;
      BTN_SYNC = 1'b1;
      tick();
      chk("press_e1_busy", {31'd0, BUSY}, 32'd1);
      chk("press_e1_valid", {31'd0, VALID}, 32'd0);
      tick();
      tick();
      tick();
      chk("press_e4_valid", {31'd0, VALID}, 32'd0);
      tick();
      chk("press_e5_valid", {31'd0, VALID}, 32'd1);
      chk("press_op_a", {24'd0, OP_A}, 32'h0C);
      chk("press_op_b", {24'd0, OP_B}, 32'h07);
      SW_SYNC = 16'hFFFF;
      tick();
      chk("frozen_op", {16'd0, OP_A, OP_B}, 32'h0C07);

      // hold with READY low for 10 cycles
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("hold_valid", {31'd0, VALID}, 32'd1);
      end
      READY = 1'b1;
      tick();
      READY = 1'b0;
      chk("xfer_valid", {31'd0, VALID}, 32'd0);
      chk("xfer_busy", {31'd0, BUSY}, 32'd1);

      // release with one bounce: 0,1,0,0,0,0
      BTN_SYNC = 1'b0;
      tick();
      BTN_SYNC = 1'b1;
      tick();
      BTN_SYNC = 1'b0;
      tick();
      tick();
      tick();
      chk("rel_z3_busy", {31'd0, BUSY}, 32'd1);
      tick();
      chk("rel_z4_busy", {31'd0, BUSY}, 32'd0);
      chk("retain_op", {16'd0, OP_A, OP_B}, 32'h0C07);

      // bounce rejection: 1,1,0,1,1,1,0
      SW_SYNC = 16'h1234;
      vcnt = 0;
      BTN_SYNC = 1'b1; tick(); vcnt += int'(VALID);
      tick(); vcnt += int'(VALID);
      BTN_SYNC = 1'b0; tick(); vcnt += int'(VALID);
      chk("bounce1_busy", {31'd0, BUSY}, 32'd0);
      BTN_SYNC = 1'b1; tick(); vcnt += int'(VALID);
      tick(); vcnt += int'(VALID);
      tick(); vcnt += int'(VALID);
      chk("bounce_mid_busy", {31'd0, BUSY}, 32'd1);
      BTN_SYNC = 1'b0; tick(); vcnt += int'(VALID);
      chk("bounce2_busy", {31'd0, BUSY}, 32'd0);
      chk("bounce_no_valid", vcnt, 32'd0);
      chk("bounce_op", {16'd0, OP_A, OP_B}, 32'h0C07);

      // one transfer per press, READY already high
      SW_SYNC = 16'hA55A;
      READY = 1'b1;
      BTN_SYNC = 1'b1;
      vcnt = 0;
      for (int i = 1; i <= 50; i++) begin
         tick();
         vcnt += int'(VALID);
         if (i == 5) chk("rdy_e5_valid", {31'd0, VALID}, 32'd1);
         if (i == 6) chk("rdy_e6_valid", {31'd0, VALID}, 32'd0);
      end
      chk("one_pulse", vcnt, 32'd1);
      chk("held_busy", {31'd0, BUSY}, 32'd1);
      chk("rdy_op", {16'd0, OP_A, OP_B}, 32'hA55A);
      BTN_SYNC = 1'b0;
      tick();
      tick();
      tick();
      chk("rel2_z3_busy", {31'd0, BUSY}, 32'd1);
      tick();
      chk("rel2_z4_busy", {31'd0, BUSY}, 32'd0);
      READY = 1'b0;

      // asynchronous reset in DB_PRESS
      BTN_SYNC = 1'b1;
      tick();
      tick();
      chk("pre_arst_busy", {31'd0, BUSY}, 32'd1);
      #2;
      RST = 1'b0;
      #1;
      chk("arst_busy", {31'd0, BUSY}, 32'd0);
      chk("arst_valid", {31'd0, VALID}, 32'd0);
      chk("arst_op", {16'd0, OP_A, OP_B}, 32'h0);
      BTN_SYNC = 1'b0;
      tick();
      RST = 1'b1;
      tick();

`ifdef CAPTURE_COUNT_EN
      chk("cnt_rst", {24'd0, CAPT_CNT}, 32'd0);
      READY = 1'b1;
      SW_SYNC = 16'h0102;
      for (int n = 1; n <= 256; n++) begin
         BTN_SYNC = 1'b1;
         for (int k = 0; k < 5; k++) tick();
         BTN_SYNC = 1'b0;
         for (int k = 0; k < 6; k++) tick();
         if (n == 1) chk("cnt_first", {24'd0, CAPT_CNT}, 32'd1);
         if (n == 100) chk("cnt_100", {24'd0, CAPT_CNT}, 32'd100);
         if (n == 255) chk("cnt_255", {24'd0, CAPT_CNT}, 32'd255);
      end
      chk("cnt_wrap", {24'd0, CAPT_CNT}, 32'd0);
      chk("cnt_idle", {31'd0, BUSY}, 32'd0);
      for (int n = 0; n < 3; n++) begin
         BTN_SYNC = 1'b1;
         tick();
         tick();
         BTN_SYNC = 1'b0;
         tick();
      end
      chk("cnt_bounce", {24'd0, CAPT_CNT}, 32'd0);
      READY = 1'b0;
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
